// File: rtl/alu_flag_branch_unit_pkg.sv
// Shared definitions for the ALU_16 flag consumer / branch resolver.
// Provides the branch condition codes and the bit positions of n/z/v
// inside the 3-bit {n,z,v} status word.
package alu_flag_branch_unit_pkg;

  typedef enum logic [2:0] {
    BR_AL = 3'd0,  // always
    BR_EQ = 3'd1,  // z
    BR_NE = 3'd2,  // !z
    BR_LT = 3'd3,  // n ^ v
    BR_GE = 3'd4,  // !(n ^ v)
    BR_MI = 3'd5,  // n
    BR_VS = 3'd6,  // v
    BR_NV = 3'd7   // never
  } br_cond_e;

  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   cond  - 3-bit condition code (br_cond_e encoding)
//   n,z,v - flag values to evaluate against
//   taken - 1 when the condition holds
module flag_cond_eval
  import alu_flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (br_cond_e'(cond))
      BR_AL: taken = 1'b1;
      BR_EQ: taken = z;
      BR_NE: taken = ~z;
      BR_LT: taken = n ^ v;
      BR_GE: taken = ~(n ^ v);
      BR_MI: taken = n;
      BR_VS: taken = v;
      BR_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_branch_unit.sv
// Consumer end of the ALU_16 flag interface.
// Latches z/v/n into a status register, tracks flag-setting ops in flight,
// and resolves conditional branches once their flags are current.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   flag_issue / issue_ready   - flag-setting op issue handshake
//   flag_valid, flag_z/v/n     - ALU_16 flag writeback
//   br_valid / br_ready        - branch request handshake
//   br_cond, br_target         - branch condition and target
//   res_valid/taken/target     - registered resolution (1-cycle pulse)
//   flags_q                    - {n,z,v} status register
//   err_spur                   - sticky: writeback seen with nothing pending
module alu_flag_branch_unit
  import alu_flag_branch_unit_pkg::*;
#(
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned AW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flag_issue,
  output logic          issue_ready,
  input  logic          flag_valid,
  input  logic          flag_z,
  input  logic          flag_v,
  input  logic          flag_n,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [2:0]    br_cond,
  input  logic [AW-1:0] br_target,
  output logic          res_valid,
  output logic          res_taken,
  output logic [AW-1:0] res_target,
  output logic [2:0]    flags_q,
  output logic          err_spur
);

  localparam int unsigned CW = $clog2(MAX_PEND + 1);

  logic [CW-1:0] pend_cnt;
  logic          issue_acc;
  logic          cnt_dec;
  logic          spurious;
  logic          forward;
  logic          uncond;
  logic [2:0]    flags_in;
  logic [2:0]    eval_flags;
  logic          cond_taken;
  logic          br_acc;

  assign flags_in    = {flag_n, flag_z, flag_v};
  assign issue_ready = (pend_cnt < CW'(MAX_PEND));
  assign issue_acc   = flag_issue & issue_ready;
  assign cnt_dec     = flag_valid & (pend_cnt != '0);
  assign spurious    = flag_valid & (pend_cnt == '0);

  // The only outstanding op writes back this cycle and no newer op issues
  // ahead of the branch: its flags can be used directly.
  assign forward     = (pend_cnt == CW'(1)) & flag_valid & ~issue_acc;
  assign uncond      = (br_cond_e'(br_cond) == BR_AL) | (br_cond_e'(br_cond) == BR_NV);
  assign br_ready    = uncond | (pend_cnt == '0) | forward;
  assign br_acc      = br_valid & br_ready;
  assign eval_flags  = forward ? flags_in : flags_q;

  flag_cond_eval u_cond_eval (
    .cond  (br_cond),
    .n     (eval_flags[FLAG_N]),
    .z     (eval_flags[FLAG_Z]),
    .v     (eval_flags[FLAG_V]),
    .taken (cond_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt   <= '0;
      flags_q    <= '0;
      err_spur   <= 1'b0;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
    end else begin
      case ({issue_acc, cnt_dec})
        2'b10:   pend_cnt <= pend_cnt + CW'(1);
        2'b01:   pend_cnt <= pend_cnt - CW'(1);
        default: pend_cnt <= pend_cnt;
      endcase
      if (flag_valid) flags_q <= flags_in;
      if (spurious) err_spur <= 1'b1;
      res_valid <= br_acc;
      if (br_acc) begin
        res_taken  <= cond_taken;
        res_target <= br_target;
      end
    end
  end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
module tb_alu_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_issue, flag_valid, flag_z, flag_v, flag_n;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic        issue_ready, br_ready, res_valid, res_taken, err_spur;
  logic [15:0] res_target;
  logic [2:0]  flags_q;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  int          m_pend;
  bit          m_n, m_z, m_v, m_err;
  bit          m_res_valid, m_res_taken;
  bit [15:0]   m_res_target;
  bit          m_stall;

  always #5 clk = ~clk;

  alu_flag_branch_unit #(.MAX_PEND(3), .AW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_issue(flag_issue), .issue_ready(issue_ready),
    .flag_valid(flag_valid), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flags_q(flags_q), .err_spur(err_spur)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input int c, input bit n, input bit z, input bit v);
    case (c)
      0: return 1;
      1: return z;
      2: return !z;
      3: return n != v;
      4: return n == v;
      5: return n;
      6: return v;
      default: return 0;
    endcase
  endfunction

  function automatic bit model_issue_ready();
    return m_pend < 3;
  endfunction

  function automatic bit model_forward();
    return (m_pend == 1) && flag_valid && !(flag_issue && model_issue_ready());
  endfunction

  function automatic bit model_br_ready();
    return (br_cond == 3'd0) || (br_cond == 3'd7) || (m_pend == 0) || model_forward();
  endfunction

  task automatic model_reset();
    m_pend = 0; m_n = 0; m_z = 0; m_v = 0; m_err = 0;
    m_res_valid = 0; m_res_taken = 0; m_res_target = '0; m_stall = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_res_valid"},  res_valid,  m_res_valid);
    chk({tag, "_res_taken"},  res_taken,  m_res_taken);
    chk({tag, "_res_target"}, res_target, m_res_target);
    chk({tag, "_flags_q"},    flags_q,    {m_n, m_z, m_v});
    chk({tag, "_err_spur"},   err_spur,   m_err);
  endtask

  // One clock cycle: inputs are set before the call (after a falling edge).
  task automatic tick(input string tag);
    bit rdy, ir, fwd, acc, fn, fz, fv;
    #1;
    ir  = model_issue_ready();
    rdy = model_br_ready();
    fwd = model_forward();
    chk({tag, "_issue_ready"}, issue_ready, ir);
    chk({tag, "_br_ready"},    br_ready,    rdy);
    @(posedge clk);
    acc = br_valid && rdy;
    if (fwd) begin fn = flag_n; fz = flag_z; fv = flag_v; end
    else     begin fn = m_n;    fz = m_z;    fv = m_v;    end
    m_res_valid = acc;
    if (acc) begin
      m_res_taken  = cond_holds(int'(br_cond), fn, fz, fv);
      m_res_target = br_target;
    end
    m_stall = br_valid && !rdy;
    if (flag_valid) begin
      if (m_pend == 0) m_err = 1;
      m_n = flag_n; m_z = flag_z; m_v = flag_v;
    end
    m_pend = m_pend + ((flag_issue && ir) ? 1 : 0) - ((flag_valid && m_pend > 0) ? 1 : 0);
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic idle();
    flag_issue = 0; flag_valid = 0; flag_z = 0; flag_v = 0; flag_n = 0;
    br_valid = 0; br_cond = 3'd0; br_target = '0;
  endtask

  task automatic set_flags(input bit n, input bit z, input bit v);
    flag_valid = 1; flag_n = n; flag_z = z; flag_v = v;
  endtask

  task automatic set_br(input int c, input logic [15:0] t);
    br_valid = 1; br_cond = 3'(c); br_target = t;
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    #12;
    check_regs("rst");
    @(negedge clk);
    rst_n = 1;

    // 1: flags from 2-1 -> all clear; LT not taken
    flag_issue = 1; tick("t1_iss"); idle();
    set_flags(0, 0, 0); tick("t1_wb"); idle();
    set_br(3, 16'h0040); tick("t1_br"); idle();
    chk("t1_taken", res_taken, 0);
    chk("t1_target", res_target, 16'h0040);
    tick("t1_idle");
    chk("t1_pulse_end", res_valid, 0);

    // 2: 0x8000-1 -> v=1; LT taken, VS taken, GE not taken (back-to-back)
    flag_issue = 1; tick("t2_iss"); idle();
    set_flags(0, 0, 1); tick("t2_wb"); idle();
    set_br(3, 16'h0100); tick("t2_lt");
    chk("t2_lt_taken", res_taken, 1);
    set_br(6, 16'h0200); tick("t2_vs");
    chk("t2_vs_taken", res_taken, 1);
    set_br(4, 16'h0300); tick("t2_ge"); idle();
    chk("t2_ge_taken", res_taken, 0);
    chk("t2_ge_valid", res_valid, 1);

    // 3: interlock with forwarding
    flag_issue = 1; tick("t3_t0"); idle();
    set_br(1, 16'h0abc); tick("t3_t1");
    chk("t3_stall", res_valid, 0);
    tick("t3_t2");
    set_flags(0, 1, 0); tick("t3_t3");
    flag_valid = 0; br_valid = 0;
    chk("t3_taken", res_taken, 1);
    chk("t3_valid", res_valid, 1);
    tick("t3_t4");

    // 4: fill, overflow attempt, drain, spurious writeback
    flag_issue = 1;
    for (int i = 0; i < 4; i++) tick("t4_fill");
    chk("t4_full", issue_ready, 0);
    idle();
    for (int i = 0; i < 3; i++) begin set_flags(0, 0, 0); tick("t4_drain"); end
    chk("t4_err_clean", err_spur, 0);
    set_flags(1, 0, 1); tick("t4_spur"); idle();
    chk("t4_err", err_spur, 1);
    chk("t4_flags", flags_q, 3'b101);

    // 5: issue + writeback at pend_cnt==1
    flag_issue = 1; tick("t5_iss"); idle();
    flag_issue = 1; set_flags(0, 1, 0); set_br(1, 16'h1234); tick("t5_both");
    idle();
    set_br(0, 16'h5678); tick("t5_al"); idle();
    chk("t5_al_taken", res_taken, 1);
    chk("t5_al_target", res_target, 16'h5678);
    set_flags(0, 0, 0); tick("t5_drain"); idle();

    // 6: reset mid-stall
    flag_issue = 1; tick("t6_a"); tick("t6_b"); idle();
    set_br(1, 16'hbeef); tick("t6_stall");
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_regs("t6_rst");
    @(negedge clk);
    rst_n = 1;
    tick("t6_after");
    idle();

    // Random traffic against the model; branch fields held while stalled
    for (int i = 0; i < 400; i++) begin
      flag_issue = ($urandom_range(0, 2) == 0);
      if (m_pend > 0) begin
        if ($urandom_range(0, 1) == 0) set_flags($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        else flag_valid = 0;
      end else begin
        if ($urandom_range(0, 19) == 0) set_flags($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        else flag_valid = 0;
      end
      if (!m_stall) begin
        br_valid  = ($urandom_range(0, 1) == 1);
        br_cond   = 3'($urandom_range(0, 7));
        br_target = 16'($urandom);
      end
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
